// File: rtl/fsm_share_pkg.sv
// -----------------------------------------------------------------------------
// fsm_share_pkg
// Shared definitions for the time-multiplexed sequence detector.
//   fsm_state_t : 2-bit per-channel detector state {s1,s2}
//   ST_RESET    : state after reset or a channel clear
//   fsm_next    : state transition for one input bit
//   fsm_out     : detector output for one input bit
// The unused encoding 2'b11 is decoded by the same equations as the others.
// -----------------------------------------------------------------------------
package fsm_share_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_RESET = 2'b01;

  function automatic fsm_state_t fsm_next(input fsm_state_t state, input logic din);
    return {din, ~din & ~state[1] & ~state[0]};
  endfunction

  function automatic logic fsm_out(input fsm_state_t state, input logic din);
    return (state[1] & state[0] & ~din) | (~state[1] & ~state[0] & din);
  endfunction

endpackage

// File: rtl/fsm_rr_arb.sv
// -----------------------------------------------------------------------------
// fsm_rr_arb
// Combinational round-robin arbiter: picks the first eligible channel scanning
// ptr, ptr+1, ... modulo NCH.
//   eligible    in  NCH  requesting and not being cleared
//   ptr         in  CW   highest-priority channel this cycle
//   adv         in  1    output stage can take a new result
//   grant       out CW   selected channel (meaningful when grant_valid)
//   grant_valid out 1    some channel is eligible
//   req_ready   out NCH  one-hot accept, gated by adv
// -----------------------------------------------------------------------------
module fsm_rr_arb #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         eligible,
  input  logic [$clog2(NCH)-1:0] ptr,
  input  logic                   adv,
  output logic [$clog2(NCH)-1:0] grant,
  output logic                   grant_valid,
  output logic [NCH-1:0]         req_ready
);

  localparam int CW = $clog2(NCH);

  logic [NCH-1:0] rot;
  logic [CW-1:0]  off;
  logic [CW:0]    sum;

  // Rotate so that bit 0 is the channel at ptr; the doubled vector makes the
  // wrap-around free for any NCH, not just powers of two.
  assign rot = NCH'({eligible, eligible} >> ptr);

  // Scan from the far end so the lowest offset is the last one written.
  always_comb begin
    off         = '0;
    grant_valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off         = CW'(i);
        grant_valid = 1'b1;
      end
    end
  end

  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign grant = (sum >= (CW+1)'(NCH)) ? CW'(sum - (CW+1)'(NCH)) : sum[CW-1:0];

  always_comb begin
    req_ready = '0;
    for (int c = 0; c < NCH; c++) begin
      req_ready[c] = adv & grant_valid & (grant == CW'(c));
    end
  end

endmodule

// File: rtl/fsm_share_sched.sv
// -----------------------------------------------------------------------------
// fsm_share_sched
// One shared 2-bit sequence-detector step serving NCH bit-stream channels.
// Per-channel state is kept locally; a round-robin arbiter grants one channel
// per cycle and the result is registered with its channel tag.
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req_valid/bit  per-channel input bit and its valid
//   req_ready      per-channel accept, one-hot or zero
//   clear          per-channel synchronous state clear (wins over a request)
//   out_valid/ready/bit/chan  registered result handshake
//   det_cnt        per-channel saturating detection counts, only when the
//                  macro FSM_SHARE_DETCNT_EN is defined
// -----------------------------------------------------------------------------
module fsm_share_sched
  import fsm_share_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req_valid,
  input  logic [NCH-1:0]         req_bit,
  output logic [NCH-1:0]         req_ready,
  input  logic [NCH-1:0]         clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bit,
`ifdef FSM_SHARE_DETCNT_EN
  output logic [NCH*CNT_W-1:0]   det_cnt,
`endif
  output logic [$clog2(NCH)-1:0] out_chan
);

  localparam int CW = $clog2(NCH);

  fsm_state_t     st [NCH];
  logic [CW-1:0]  ptr;
  logic [NCH-1:0] eligible;
  logic [CW-1:0]  grant;
  logic           grant_valid;
  logic           adv;
  logic           xfer;
  fsm_state_t     sel_st;
  logic           sel_bit;
  fsm_state_t     nxt_st;
  logic           det;

  logic           vld_p0;
  logic           bit_p0;
  logic [CW-1:0]  chan_p0;

  assign adv      = ~vld_p0 | out_ready;
  assign eligible = req_valid & ~clear;

  fsm_rr_arb #(.NCH(NCH)) u_arb (
    .eligible    (eligible),
    .ptr         (ptr),
    .adv         (adv),
    .grant       (grant),
    .grant_valid (grant_valid),
    .req_ready   (req_ready)
  );

  // An eligible channel always has req_valid high, so a grant while the
  // output can advance is exactly a handshake on the granted channel.
  assign xfer    = grant_valid & adv;
  assign sel_st  = st[grant];
  assign sel_bit = req_bit[grant];
  assign nxt_st  = fsm_next(sel_st, sel_bit);
  assign det     = fsm_out(sel_st, sel_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) st[c] <= ST_RESET;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clear[c])                          st[c] <= ST_RESET;
        else if (xfer && (grant == CW'(c)))    st[c] <= nxt_st;
      end
    end
  end

  // ---- stage p0: registered result, held while downstream stalls ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      bit_p0  <= 1'b0;
      chan_p0 <= '0;
      ptr     <= '0;
    end else if (adv) begin
      vld_p0 <= xfer;
      if (xfer) begin
        bit_p0  <= det;
        chan_p0 <= grant;
        ptr     <= (grant == CW'(NCH - 1)) ? '0 : grant + CW'(1);
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_bit   = bit_p0;
  assign out_chan  = chan_p0;

`ifdef FSM_SHARE_DETCNT_EN
  logic [CNT_W-1:0] cnt [NCH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clear[c])                                cnt[c] <= '0;
        else if (xfer && det && (grant == CW'(c)))   cnt[c] <= sat_inc(cnt[c]);
      end
    end
  end

  always_comb begin
    det_cnt = '0;
    for (int c = 0; c < NCH; c++) det_cnt[c*CNT_W +: CNT_W] = cnt[c];
  end
`else
  // CNT_W only sizes the counters; without them it is checked for sanity only.
  if (CNT_W < 1) begin : g_cnt_w_unsized
  end
`endif

endmodule

// File: tb/tb_fsm_share_sched.sv
// -----------------------------------------------------------------------------
// tb_fsm_share_sched
// Self-checking bench for fsm_share_sched (NCH=4, CNT_W=8). Builds with or
// without FSM_SHARE_DETCNT_EN.
// -----------------------------------------------------------------------------
module tb_fsm_share_sched;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] req_valid = '0;
  logic [NCH-1:0] req_bit   = '0;
  logic [NCH-1:0] clear     = '0;
  logic [NCH-1:0] req_ready;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic           out_bit;
  logic [1:0]     out_chan;
`ifdef FSM_SHARE_DETCNT_EN
  logic [NCH*CNT_W-1:0] det_cnt;
`endif

  always #5 clk = ~clk;

  fsm_share_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bit   (req_bit),
    .req_ready (req_ready),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
`ifdef FSM_SHARE_DETCNT_EN
    .det_cnt   (det_cnt),
`endif
    .out_chan  (out_chan)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [1:0] m_st [NCH];
  int         m_ptr;
  int         m_cnt [NCH];

  typedef struct {
    logic       b;
    logic [1:0] ch;
  } res_t;
  res_t sbq[$];

  typedef struct {
    bit         do_rst;
    logic [3:0] vld;
    logic [3:0] bits;
    logic [3:0] clr;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic       e_bit;
    logic [1:0] e_chan;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Detector step as a truth table, returns {out, next_state}
  function automatic logic [2:0] ref_step(input logic [1:0] s, input logic i);
    case ({s, i})
      3'b000: return 3'b001;
      3'b001: return 3'b110;
      3'b010: return 3'b000;
      3'b011: return 3'b010;
      3'b100: return 3'b000;
      3'b101: return 3'b010;
      3'b110: return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_st[c]  = 2'b01;
      m_cnt[c] = 0;
    end
    m_ptr = 0;
    sbq.delete();
  endtask

  // Asynchronous reset; outputs are checked before any clock edge occurs.
  task automatic do_reset();
    req_valid = '0; req_bit = '0; clear = '0; out_ready = 1'b1;
    rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bit", out_bit, 1'b0);
    check("rst_out_chan", out_chan, 2'd0);
    check("rst_req_ready", req_ready, 4'b0000);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Inputs are already applied (posedge+1). Checks mid-cycle, advances the
  // model, and returns at the following posedge+1.
  task automatic run_cycle(output logic [NCH-1:0] seen_rdy);
    logic           adv;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] e_rdy;
    int             g;
    int             idx;
    logic [2:0]     r;
    res_t           e;
    #3;
    seen_rdy = req_ready;
    adv  = (sbq.size() == 0) || out_ready;
    elig = req_valid & ~clear;
    e_rdy = '0;
    g = -1;
    r = 3'b000;
    if (adv) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (m_ptr + k) % NCH;
        if (g < 0 && elig[idx[1:0]]) g = idx;
      end
    end
    if (g >= 0) e_rdy[g[1:0]] = 1'b1;
    check("req_ready", req_ready, e_rdy);
    check("out_valid", out_valid, sbq.size() != 0);
    if (sbq.size() != 0) begin
      check("out_bit", out_bit, sbq[0].b);
      check("out_chan", out_chan, sbq[0].ch);
      if (out_ready) void'(sbq.pop_front());
    end
    if (g >= 0) begin
      r = ref_step(m_st[g], req_bit[g[1:0]]);
      e.b  = r[2];
      e.ch = g[1:0];
      sbq.push_back(e);
      if (r[2] && m_cnt[g] < 255) m_cnt[g]++;
      m_ptr = (g + 1) % NCH;
    end
    for (int c = 0; c < NCH; c++) begin
      if (clear[c]) begin
        m_st[c]  = 2'b01;
        m_cnt[c] = 0;
      end else if (c == g) begin
        m_st[c] = r[1:0];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic add(input bit rs, input logic [3:0] v, input logic [3:0] b, input logic [3:0] cl,
                     input logic ordy, input logic [3:0] erdy, input logic ev, input logic eb,
                     input logic [1:0] ech);
    vec_t t;
    t.do_rst = rs; t.vld = v; t.bits = b; t.clr = cl; t.ordy = ordy;
    t.e_rdy = erdy; t.e_vld = ev; t.e_bit = eb; t.e_chan = ech;
    tbl.push_back(t);
  endtask

  initial begin
    logic [NCH-1:0] seen;

    // Reset then ch0 alone: bits 1,0,1 -> 0,0,1
    add(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 2'd0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 2'd0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 2'd0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 2'd0);
    // Round robin ch0 (1,0,1) against ch1 (0,0,0)
    add(1, 4'b0011, 4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 2'd0);
    add(0, 4'b0011, 4'b0000, 4'b0000, 1, 4'b0010, 1, 0, 2'd1);
    add(0, 4'b0011, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 2'd0);
    add(0, 4'b0011, 4'b0001, 4'b0000, 1, 4'b0010, 1, 0, 2'd1);
    add(0, 4'b0011, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 2'd0);
    add(0, 4'b0011, 4'b0000, 4'b0000, 1, 4'b0010, 1, 0, 2'd1);
    // Backpressure with ch2 waiting, then release
    add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 1, 0, 2'd1);
    add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 1, 0, 2'd1);
    add(0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000, 1, 0, 2'd1);
    add(0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 2'd2);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 2'd2);
    // Clear colliding with a request on ch0 at state 00
    add(1, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 2'd0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 2'd0);
    add(0, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 2'd0);
    add(0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 2'd0);
    // ch1 to state 10 with a result in flight, then reset mid-operation
    add(1, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 2'd1);
    add(1, 4'b0011, 4'b0011, 4'b0000, 1, 4'b0001, 1, 0, 2'd0);
    add(0, 4'b0010, 4'b0000, 4'b0000, 1, 4'b0010, 1, 0, 2'd1);
    add(0, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 2'd1);

    #1;
    foreach (tbl[n]) begin
      if (tbl[n].do_rst) do_reset();
      req_valid = tbl[n].vld;
      req_bit   = tbl[n].bits;
      clear     = tbl[n].clr;
      out_ready = tbl[n].ordy;
      run_cycle(seen);
      check($sformatf("tbl%0d_rdy", n), seen, tbl[n].e_rdy);
      check($sformatf("tbl%0d_vld", n), out_valid, tbl[n].e_vld);
      check($sformatf("tbl%0d_bit", n), out_bit, tbl[n].e_bit);
      check($sformatf("tbl%0d_chan", n), out_chan, tbl[n].e_chan);
    end

    // Random traffic on all channels with random clears and backpressure
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_bit   = 4'($urandom_range(0, 15));
      clear     = ($urandom_range(0, 7) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      out_ready = ($urandom_range(0, 3) != 0);
      run_cycle(seen);
    end

`ifdef FSM_SHARE_DETCNT_EN
    do_reset();
    for (int rep = 0; rep < 300; rep++) begin
      for (int k = 0; k < 3; k++) begin
        req_valid = 4'b0001;
        req_bit   = {3'b000, (k != 1)};
        clear     = '0;
        out_ready = 1'b1;
        run_cycle(seen);
      end
      if (rep == 9) check("det_cnt0_10", det_cnt[CNT_W-1:0], 8'd10);
    end
    check("det_cnt0_sat", det_cnt[CNT_W-1:0], 8'd255);
    check("det_cnt0_model", det_cnt[CNT_W-1:0], m_cnt[0]);
    check("det_cnt_others", det_cnt[NCH*CNT_W-1:CNT_W], 24'd0);
    clear = 4'b0001;
    req_valid = '0;
    run_cycle(seen);
    check("det_cnt0_clear", det_cnt[CNT_W-1:0], 8'd0);
`endif

    req_valid = '0;
    clear     = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_share_sched.md
Name: fsm_share_sched

Overview:
- Time-multiplexed scheduler that shares one 2-bit sequence-detector step (state transition plus output function) among NCH independent bit-stream requesters.
- Keeps per-channel FSM state, arbitrates round-robin with valid/ready handshakes, and emits one registered result tagged with its channel.
- Sits between serial input sources and downstream detection consumers.
- Replaces NCH separate detector instances.

Parameters:
- NCH, 4: number of requesting channels, 2..16.
- CNT_W, 8: width of the per-channel detection counter (optional feature only).
- Derived localparam CW = $clog2(NCH): channel-index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NCH  per-channel input bit valid
- req_bit  in  NCH  per-channel input bit
- req_ready  out  NCH  per-channel accept; at most one bit high (one-hot or zero)
- clear  in  NCH  per-channel synchronous state clear
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_bit  out  1  detector output for the accepted bit
- out_chan  out  CW  channel index of the result
- det_cnt  out  NCH*CNT_W  per-channel saturating detection counts; present only with the optional feature

Behaviour:
- Per-channel state st[c] is 2 bits {s1,s2}. Reset/clear value is 2'b01.
- Step function, with s = st[c] and i = req_bit[c]:
  - next = {i, !i & !s1 & !s2}
  - out = (s1 & s2 & !i) | (!s1 & !s2 & i)
  - State 11 is unreachable but must still be decoded per these equations.
- adv = !out_valid | out_ready.
- eligible[c] = req_valid[c] & !clear[c].
- Grant goes to the first eligible channel scanning ptr, ptr+1, ... modulo NCH.
- req_ready[c] = adv & grant_valid & (grant == c). This is combinational; there is no path from req_valid to req_ready of other channels beyond arbitration.
- Transfer on channel c occurs when req_valid[c] & req_ready[c]. At the next edge:
  - st[c] <= next
  - out_bit <= out, out_chan <= c, out_valid <= 1
  - ptr <= (c+1) mod NCH
- Latency: result is visible 1 cycle after acceptance. Throughput: 1 result per cycle when out_ready is held high.
- No transfer and out_ready=1: out_valid <= 0. out_bit and out_chan hold their last values.
- out_valid=1 and out_ready=0: all req_ready are 0; out_valid, out_bit and out_chan are held stable; ptr and all st are unchanged.
- clear[c]: st[c] <= 2'b01 at the next edge. Channel c is masked from grant that cycle, so clear wins over a simultaneous request. Clearing a channel does not affect an already-registered result for that channel.
- No eligible channel: ptr unchanged.
- Reset, including mid-operation, clears asynchronously:
  - all st to 01
  - ptr to 0
  - out_valid 0, out_bit 0, out_chan 0
  - det_cnt 0
  - An in-flight result is discarded.
- The combinational output out_bit depends only on registered values.

Optional Feature:
- Macro FSM_SHARE_DETCNT_EN.
- Defined:
  - det_cnt port exists.
  - Counter cnt[c] increments on each transfer of channel c whose computed out=1.
  - Saturates at 2^CNT_W-1.
  - Reset to 0 by rst or clear[c].
- Undefined: no det_cnt port, no counter logic. All other behaviour is identical.

Decomposition:
- Package fsm_share_pkg holds:
  - typedef fsm_state_t (logic [1:0])
  - constant ST_RESET = 2'b01
  - pure function fsm_next(state, in)
  - pure function fsm_out(state, in)
- Sub-module fsm_rr_arb (NCH parameter): inputs eligible, ptr, adv; outputs grant index, grant_valid, req_ready one-hot.
- The state array, output register and counters stay in fsm_share_sched.

Test Plan:
- Reset check: after rst, out_valid=0, req_ready=0 with no requests, ptr=0. Internal st[*]=01, verified via the ch0 sequence below.
- Single channel: ch0 sends bits 1,0,1 on consecutive cycles with out_ready=1.
  - Required: results out_bit 0,0,1, out_chan=0, each valid 1 cycle after accept.
  - Final st[0]=10.
- Round-robin interleave: ch0 and ch1 always valid, ch0 bits 1,0,1 and ch1 bits 0,0,0.
  - Required: grants alternate 0,1,0,1,0,1.
  - ch0 results 0,0,1; ch1 results 0,0,0. States are independent.
- Backpressure: hold out_ready=0 while out_valid=1 for 3 cycles with ch2 valid.
  - Required: req_ready=0, output fields stable, no st change.
  - Release out_ready: ch2 is accepted next cycle.
- Clear collision: ch0 at st=00 (after 1,0), assert clear[0] and req_valid[0] with bit 1 in the same cycle.
  - Required: req_ready[0]=0 and st[0]=01.
  - Next bit 1 gives out_bit=0, not 1.
- Reset mid-operation: assert rst while out_valid=1 and ch1 at st=10.
  - Required: out_valid drops immediately and st[1]=01 afterwards.
  - With FSM_SHARE_DETCNT_EN defined: ch0 sequence 1,0,1 repeated 300 times saturates det_cnt[0] at 255 (CNT_W=8). Each repetition yields one detection.
